// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    RV_HI,
    RV_LO,
    RUN,
    IMM,
    IV_HI,
    IV_LO
  } fetch_state_t;

  localparam logic [15:0] NOP_WORD = 16'h4000;

  localparam int unsigned RESET_VEC_ADDR_DEFAULT = 0;
  localparam int unsigned INT_VEC_ADDR_DEFAULT   = 2;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction memory, decode handshake and redirect inputs.
// FETCH_PERF_EN adds the perf counter outputs.
interface fetch_sequencer_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            interrupt;
  logic            is_two_word;
  logic [15:0]     mem_word;
  logic [PC_W-1:0] mem_addr;
  logic            instruction_valid;
  logic            clear_instruction;
  logic            imm_valid;
  logic [PC_W-1:0] pc_plus_one;
  logic [PC_W-1:0] saved_pc;
  logic            int_ack;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_bubbles;
`endif

  modport master (
    input  stall, branch_taken, branch_target, interrupt, is_two_word, mem_word,
    output mem_addr, instruction_valid, clear_instruction, imm_valid,
           pc_plus_one, saved_pc, int_ack
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_bubbles
`endif
  );

  modport slave (
    output stall, branch_taken, branch_target, interrupt, is_two_word, mem_word,
    input  mem_addr, instruction_valid, clear_instruction, imm_valid,
           pc_plus_one, saved_pc, int_ack
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_bubbles
`endif
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, loads reset/interrupt vectors, issues 1- and 2-word
// instructions. Optional perf counters under FETCH_PERF_EN.
//
// state | meaning
// RV_HI | load reset vector high word
// RV_LO | load reset vector low word
// RUN   | issue instruction at pc
// IMM   | pass immediate word of previous instruction
// IV_HI | load interrupt vector high word
// IV_LO | load interrupt vector low word
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          PC_W           = 32,
  parameter int unsigned RESET_VEC_ADDR = RESET_VEC_ADDR_DEFAULT,
  parameter int unsigned INT_VEC_ADDR   = INT_VEC_ADDR_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  localparam logic [PC_W-1:0] RV_ADDR = PC_W'(RESET_VEC_ADDR);
  localparam logic [PC_W-1:0] IV_ADDR = PC_W'(INT_VEC_ADDR);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] saved_pc;
  logic            int_pending;

  logic            int_req;
  logic            accept_int;
  logic            issue;
  logic            imm_take;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] mem_addr;

  always_comb begin
    int_req    = int_pending | bus.interrupt;
    // Never accept into the middle of a two-word instruction.
    accept_int = (state == RUN) && !bus.branch_taken && !bus.stall &&
                 int_req && !bus.is_two_word;
    issue      = (state == RUN) && !bus.stall && !bus.branch_taken && !accept_int;
    imm_take   = (state == IMM) && !bus.stall && !bus.branch_taken;
    pc_next    = pc + 1'b1;
    mem_addr   = pc;
    case (state)
      RV_HI:   mem_addr = RV_ADDR;
      RV_LO:   mem_addr = RV_ADDR + 1'b1;
      IV_HI:   mem_addr = IV_ADDR;
      IV_LO:   mem_addr = IV_ADDR + 1'b1;
      default: mem_addr = pc;
    endcase
  end

  assign bus.mem_addr          = mem_addr;
  assign bus.instruction_valid = issue;
  assign bus.clear_instruction = !issue;
  assign bus.imm_valid         = imm_take;
  assign bus.pc_plus_one       = pc_next;
  assign bus.saved_pc          = saved_pc;
  assign bus.int_ack           = accept_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RV_HI;
      pc          <= '0;
      saved_pc    <= '0;
      int_pending <= 1'b0;
    end else begin
      int_pending <= int_req & ~accept_int;
      case (state)
        RV_HI: begin
          pc[PC_W-1:16] <= bus.mem_word;
          state         <= RV_LO;
        end
        RV_LO: begin
          pc[15:0] <= bus.mem_word;
          state    <= RUN;
        end
        IV_HI: begin
          pc[PC_W-1:16] <= bus.mem_word;
          state         <= IV_LO;
        end
        IV_LO: begin
          pc[15:0] <= bus.mem_word;
          state    <= RUN;
        end
        RUN, IMM: begin
          if (bus.branch_taken) begin
            pc    <= bus.branch_target;
            state <= RUN;
          end else if (accept_int) begin
            saved_pc <= pc;
            state    <= IV_HI;
          end else if (!bus.stall) begin
            pc    <= pc_next;
            state <= (state == RUN && bus.is_two_word) ? IMM : RUN;
          end
        end
        default: state <= RV_HI;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (issue) perf_fetched <= perf_fetched + 32'd1;
      if (!issue && (state == RUN || state == IMM)) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched;
  assign bus.perf_bubbles = perf_bubbles;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: per-cycle stimulus rows push expected outputs,
// which are popped and compared once the combinational outputs settle.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(32)) bus ();

  fetch_sequencer #(.PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [0:1023];
  logic        tw  [0:1023];
  assign bus.mem_word    = mem[bus.mem_addr[9:0]];
  assign bus.is_two_word = tw[bus.mem_addr[9:0]];

  typedef struct {
    string       nm;
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        irq;
    logic [35:0] expv;
    int          aux_sel;
    logic [31:0] aux;
  } row_t;

  row_t exp_q [$];
  int checks = 0;
  int passed = 0;

  function automatic row_t mk(string nm, logic st, logic br, logic [31:0] tgt, logic irq,
                              logic [31:0] a, logic iv, logic clr, logic immv, logic ack,
                              int aux_sel = 0, logic [31:0] aux = 32'd0);
    row_t r;
    r.nm = nm; r.st = st; r.br = br; r.tgt = tgt; r.irq = irq;
    r.expv = {a, iv, clr, immv, ack};
    r.aux_sel = aux_sel; r.aux = aux;
    return r;
  endfunction

  task automatic drive(input row_t r);
    bus.stall         = r.st;
    bus.branch_taken  = r.br;
    bus.branch_target = r.tgt;
    bus.interrupt     = r.irq;
    exp_q.push_back(r);
  endtask

  function automatic logic [35:0] obs_vec();
    return {bus.mem_addr, bus.instruction_valid, bus.clear_instruction, bus.imm_valid, bus.int_ack};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.interrupt = 0;
    #1;
    checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_addr); else passed++;
    checks++; if (bus.clear_instruction !== 1'b1) $display("FAIL reset_clr: got %b want 1", bus.clear_instruction); else passed++;
    checks++; if (bus.instruction_valid !== 1'b0) $display("FAIL reset_iv: got %b want 0", bus.instruction_valid); else passed++;
    checks++; if (bus.imm_valid !== 1'b0) $display("FAIL reset_imm: got %b want 0", bus.imm_valid); else passed++;
    checks++; if (bus.int_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.int_ack); else passed++;
    checks++; if (bus.saved_pc !== 32'h0) $display("FAIL reset_saved_pc: got %h want 0", bus.saved_pc); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_vector();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("rv_hi",  0, 0, 0, 0, 32'h0,  0, 1, 0, 0));
    rows.push_back(mk("rv_lo",  0, 0, 0, 0, 32'h1,  0, 1, 0, 0));
    rows.push_back(mk("run_20", 0, 0, 0, 0, 32'h20, 1, 0, 0, 0, 1, 32'h21));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (e.aux_sel != 0) begin
        checks++;
        o[31:0] = (e.aux_sel == 1) ? bus.pc_plus_one : bus.saved_pc;
        if (o[31:0] !== e.aux) $display("FAIL %s_aux: got %h want %h", e.nm, o[31:0], e.aux); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_two_word();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("imm_21", 0, 0, 0, 0, 32'h21, 0, 1, 1, 0));
    rows.push_back(mk("run_22", 0, 0, 0, 0, 32'h22, 1, 0, 0, 0, 1, 32'h23));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (e.aux_sel != 0) begin
        checks++;
        o[31:0] = (e.aux_sel == 1) ? bus.pc_plus_one : bus.saved_pc;
        if (o[31:0] !== e.aux) $display("FAIL %s_aux: got %h want %h", e.nm, o[31:0], e.aux); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_vs_int();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("br_st_irq", 1, 1, 32'h100, 1, 32'h23,  0, 1, 0, 0));
    rows.push_back(mk("pend_ack",  0, 0, 0,       0, 32'h100, 0, 1, 0, 1));
    rows.push_back(mk("iv_hi",     0, 0, 0,       0, 32'h2,   0, 1, 0, 0, 2, 32'h100));
    rows.push_back(mk("iv_lo",     0, 0, 0,       0, 32'h3,   0, 1, 0, 0));
    rows.push_back(mk("isr_200",   0, 0, 0,       0, 32'h200, 1, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (e.aux_sel != 0) begin
        checks++;
        o[31:0] = (e.aux_sel == 1) ? bus.pc_plus_one : bus.saved_pc;
        if (o[31:0] !== e.aux) $display("FAIL %s_aux: got %h want %h", e.nm, o[31:0], e.aux); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_int_in_imm();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("br_30",    0, 1, 32'h30, 0, 32'h201, 0, 1, 0, 0));
    rows.push_back(mk("run_30",   0, 0, 0,      0, 32'h30,  1, 0, 0, 0));
    rows.push_back(mk("imm_irq",  0, 0, 0,      1, 32'h31,  0, 1, 1, 0));
    rows.push_back(mk("ack_32",   0, 0, 0,      0, 32'h32,  0, 1, 0, 1));
    rows.push_back(mk("iv_hi2",   0, 0, 0,      0, 32'h2,   0, 1, 0, 0, 2, 32'h32));
    rows.push_back(mk("iv_lo2",   0, 0, 0,      0, 32'h3,   0, 1, 0, 0));
    rows.push_back(mk("isr_200b", 0, 0, 0,      0, 32'h200, 1, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (e.aux_sel != 0) begin
        checks++;
        o[31:0] = (e.aux_sel == 1) ? bus.pc_plus_one : bus.saved_pc;
        if (o[31:0] !== e.aux) $display("FAIL %s_aux: got %h want %h", e.nm, o[31:0], e.aux); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("br_40",   0, 1, 32'h40, 0, 32'h201, 0, 1, 0, 0));
    rows.push_back(mk("stall_1", 1, 0, 0,      0, 32'h40,  0, 1, 0, 0));
    rows.push_back(mk("stall_2", 1, 0, 0,      0, 32'h40,  0, 1, 0, 0));
    rows.push_back(mk("stall_3", 1, 0, 0,      0, 32'h40,  0, 1, 0, 0));
    rows.push_back(mk("run_40",  0, 0, 0,      0, 32'h40,  1, 0, 0, 0));
    rows.push_back(mk("run_41",  0, 0, 0,      0, 32'h41,  1, 0, 0, 0, 1, 32'h42));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (e.aux_sel != 0) begin
        checks++;
        o[31:0] = (e.aux_sel == 1) ? bus.pc_plus_one : bus.saved_pc;
        if (o[31:0] !== e.aux) $display("FAIL %s_aux: got %h want %h", e.nm, o[31:0], e.aux); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("br_top",   0, 1, 32'hFFFF_FFFF, 0, 32'h42,        0, 1, 0, 0));
    rows.push_back(mk("run_top",  0, 0, 0,             0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 32'h0));
    rows.push_back(mk("imm_wrap", 0, 0, 0,             0, 32'h0,         0, 1, 1, 0));
    rows.push_back(mk("run_1",    0, 0, 0,             0, 32'h1,         1, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (e.aux_sel != 0) begin
        checks++;
        o[31:0] = (e.aux_sel == 1) ? bus.pc_plus_one : bus.saved_pc;
        if (o[31:0] !== e.aux) $display("FAIL %s_aux: got %h want %h", e.nm, o[31:0], e.aux); else passed++;
      end
      @(negedge clk);
    end
  endtask

  // Two pulses during stall merge into one ack, deferred past a two-word instruction.
  task automatic test_pending_merge();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("br_20",   0, 1, 32'h20, 0, 32'h2,   0, 1, 0, 0));
    rows.push_back(mk("st_irq1", 1, 0, 0,      1, 32'h20,  0, 1, 0, 0));
    rows.push_back(mk("st_irq2", 1, 0, 0,      1, 32'h20,  0, 1, 0, 0));
    rows.push_back(mk("tw_hold", 0, 0, 0,      0, 32'h20,  1, 0, 0, 0));
    rows.push_back(mk("imm_hld", 0, 0, 0,      0, 32'h21,  0, 1, 1, 0));
    rows.push_back(mk("ack_22",  0, 0, 0,      0, 32'h22,  0, 1, 0, 1));
    rows.push_back(mk("iv_hi3",  0, 0, 0,      0, 32'h2,   0, 1, 0, 0, 2, 32'h22));
    rows.push_back(mk("iv_lo3",  0, 0, 0,      0, 32'h3,   0, 1, 0, 0));
    rows.push_back(mk("no_2nd",  0, 0, 0,      0, 32'h200, 1, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (e.aux_sel != 0) begin
        checks++;
        o[31:0] = (e.aux_sel == 1) ? bus.pc_plus_one : bus.saved_pc;
        if (o[31:0] !== e.aux) $display("FAIL %s_aux: got %h want %h", e.nm, o[31:0], e.aux); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_load_reset();
    row_t rows [$];
    row_t e;
    logic [35:0] o;
    rows.push_back(mk("ack_201", 0, 0, 0, 1, 32'h201, 0, 1, 0, 1));
    rows.push_back(mk("iv_hi4",  0, 0, 0, 0, 32'h2,   0, 1, 0, 0));
    rows.push_back(mk("iv_lo4",  0, 0, 0, 0, 32'h3,   0, 1, 0, 0));
    rows.push_back(mk("rv_hi2",  0, 0, 0, 0, 32'h0,   0, 1, 0, 0));
    rows.push_back(mk("rv_lo2",  0, 0, 0, 0, 32'h1,   0, 1, 0, 0));
    rows.push_back(mk("run_20b", 0, 0, 0, 0, 32'h20,  1, 0, 0, 0));
    foreach (rows[i]) begin
      if (i == 3) begin
        @(negedge clk);
        reset = 1'b1;
      end
      drive(rows[i]); #1;
      e = exp_q.pop_front(); o = obs_vec();
      checks++;
      if (o !== e.expv) $display("FAIL %s: addr/iv/clr/imm/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", e.nm,
        o[35:4], o[3], o[2], o[1], o[0], e.expv[35:4], e.expv[3], e.expv[2], e.expv[1], e.expv[0]);
      else passed++;
      if (i == 2) begin
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_addr !== 32'h0) $display("FAIL midrst_addr: got %h want 0", bus.mem_addr); else passed++;
        checks++; if (bus.int_ack !== 1'b0) $display("FAIL midrst_ack: got %b want 0", bus.int_ack); else passed++;
        checks++; if (bus.clear_instruction !== 1'b1) $display("FAIL midrst_clr: got %b want 1", bus.clear_instruction); else passed++;
        checks++; if (bus.saved_pc !== 32'h0) $display("FAIL midrst_saved_pc: got %h want 0", bus.saved_pc); else passed++;
      end
      if (i != 2) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = NOP_WORD;
      tw[i]  = 1'b0;
    end
    mem[0] = 16'h0000; mem[1] = 16'h0020;
    mem[2] = 16'h0000; mem[3] = 16'h0200;
    tw[10'h020] = 1'b1;
    tw[10'h030] = 1'b1;
    tw[10'h3FF] = 1'b1;

    test_reset();
    test_reset_vector();
    test_two_word();
    test_branch_vs_int();
    test_int_in_imm();
    test_stall();
    test_wrap();
    test_pending_merge();
    test_mid_load_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
